// File: rtl/fmrv32im_dcache_wb_pkg.sv
// Shared constants for the fmrv32im write-back data cache: FSM encodings and
// address-split / burst-length helpers.
package fmrv32im_cache_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WB_REQ  = 3'd1;
  localparam logic [2:0] ST_WB_WAIT = 3'd2;
  localparam logic [2:0] ST_RF_REQ  = 3'd3;
  localparam logic [2:0] ST_RF_WAIT = 3'd4;
  localparam logic [2:0] ST_FL_SCAN = 3'd5;
  localparam logic [2:0] ST_FL_REQ  = 3'd6;
  localparam logic [2:0] ST_FL_WAIT = 3'd7;

  function automatic int idx_bits(input int lines);
    return (lines > 1) ? $clog2(lines) : 0;
  endfunction

  // Tag covers ADDR[29:WA+2+IB]; bits 31:30 only select the RAM window.
  function automatic int tag_bits(input int lines, input int line_words);
    return 28 - $clog2(line_words) - idx_bits(lines);
  endfunction

  function automatic logic [15:0] req_len(input int line_words);
    return 16'(line_words * 4);
  endfunction

endpackage

// File: rtl/fmrv32im_dcache_wb_if.sv
// Burst request channel between the data cache and the local AXI4 master.
interface fmrv32im_dcache_wb_if #(
  parameter int WA = 10
);
  // Handshake: the cache raises *_START for exactly one cycle, only while
  // *_READY is high; the master drops READY within one cycle of START and
  // raises it again when the burst has completed.
  logic          WR_REQ_START;
  logic [31:0]   WR_REQ_ADDR;
  logic [15:0]   WR_REQ_LEN;
  logic          WR_REQ_READY;
  logic [WA-1:0] WR_REQ_MEM_ADDR;
  logic [31:0]   WR_REQ_MEM_WDATA;
  logic          RD_REQ_START;
  logic [31:0]   RD_REQ_ADDR;
  logic [15:0]   RD_REQ_LEN;
  logic          RD_REQ_READY;
  logic          RD_REQ_MEM_WE;
  logic [WA-1:0] RD_REQ_MEM_ADDR;
  logic [31:0]   RD_REQ_MEM_RDATA;

  modport master (
    output WR_REQ_START, WR_REQ_ADDR, WR_REQ_LEN, WR_REQ_MEM_WDATA,
    output RD_REQ_START, RD_REQ_ADDR, RD_REQ_LEN,
    input  WR_REQ_READY, WR_REQ_MEM_ADDR,
    input  RD_REQ_READY, RD_REQ_MEM_WE, RD_REQ_MEM_ADDR, RD_REQ_MEM_RDATA
  );

  modport slave (
    input  WR_REQ_START, WR_REQ_ADDR, WR_REQ_LEN, WR_REQ_MEM_WDATA,
    input  RD_REQ_START, RD_REQ_ADDR, RD_REQ_LEN,
    output WR_REQ_READY, WR_REQ_MEM_ADDR,
    output RD_REQ_READY, RD_REQ_MEM_WE, RD_REQ_MEM_ADDR, RD_REQ_MEM_RDATA
  );
endinterface

// File: rtl/fmrv32im_dcache_wb_dpram.sv
// Cache data store: true dual-port RAM with registered reads. Port A serves
// the core (byte-enabled), port B serves refill writes and write-back reads.
module fmrv32im_cache_dpram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          a_en,
  input  logic [3:0]    a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic [31:0]   b_rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (a_en) begin
      for (int i = 0; i < 4; i++) begin
        if (a_we[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
    if (b_we) mem[b_addr] <= b_wdata;
    b_rdata <= mem[b_addr];
    // Only the core-facing read register is cleared so RDATA starts at zero.
    if (RST) a_rdata <= '0;
    else if (a_en && (a_we == 4'b0000)) a_rdata <= mem[a_addr];
  end
endmodule

// File: rtl/fmrv32im_dcache_wb.sv
// Direct-mapped write-back data cache between the fmrv32im D_MEM port and the
// AXI4 master request channel, with an explicit flush of all dirty lines.
module fmrv32im_dcache_wb
  import fmrv32im_cache_pkg::*;
#(
  parameter int  LINES      = 4,
  parameter int  LINE_WORDS = 1024,
  localparam int WA         = $clog2(LINE_WORDS)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        D_MEM_ENA,
  input  logic [3:0]  D_MEM_WSTB,
  input  logic [31:0] D_MEM_ADDR,
  input  logic [31:0] D_MEM_WDATA,
  output logic        D_MEM_WAIT,
  output logic [31:0] D_MEM_RDATA,
  output logic        D_MEM_BADMEM_EXCPT,
  input  logic        FLUSH_REQ,
  output logic        FLUSH_DONE,
  output logic [2:0]  DBG_STATE,
  fmrv32im_dcache_wb_if.master req
);
  localparam int IB  = idx_bits(LINES);
  localparam int IBW = (IB > 0) ? IB : 1;
  localparam int TW  = tag_bits(LINES, LINE_WORDS);
  localparam int OFS = WA + 2;
  localparam int AW  = WA + IB;

  logic [2:0]       state_q;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0]    tag_q [LINES];
  logic [IBW-1:0]   req_idx_q;
  logic [31:0]      rf_addr_q;
  logic             flush_pend_q, flush_done_q;

  logic           in_window, hit, last_idx, line_dirty, ram_b_we;
  logic [WA-1:0]  a_off, b_off;
  logic [IBW-1:0] a_idx;
  logic [TW-1:0]  a_tag, rf_tag;
  logic [AW-1:0]  ram_a_addr, ram_b_addr;
  logic [31:0]    ram_b_rdata;

  function automatic logic [IBW-1:0] idx_of(input logic [31:0] a);
    return IBW'((a >> OFS) & 32'(LINES - 1));
  endfunction

  function automatic logic [TW-1:0] tag_of(input logic [31:0] a);
    return TW'(a[29:0] >> (OFS + IB));
  endfunction

  assign in_window  = (D_MEM_ADDR[31:30] == 2'b00);
  assign a_off      = D_MEM_ADDR[WA+1:2];
  assign a_idx      = idx_of(D_MEM_ADDR);
  assign a_tag      = tag_of(D_MEM_ADDR);
  assign rf_tag     = tag_of(rf_addr_q);
  assign hit        = (state_q == ST_IDLE) && D_MEM_ENA && in_window &&
                      valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign last_idx   = (req_idx_q == IBW'(LINES - 1));
  assign line_dirty = valid_q[req_idx_q] && dirty_q[req_idx_q];

  assign D_MEM_WAIT         = D_MEM_ENA && in_window && !hit;
  assign D_MEM_BADMEM_EXCPT = D_MEM_ENA && !in_window;
  assign FLUSH_DONE         = flush_done_q;
  assign DBG_STATE          = state_q;

  assign req.WR_REQ_START = (state_q == ST_WB_REQ) || (state_q == ST_FL_REQ);
  assign req.WR_REQ_ADDR  = (32'(tag_q[req_idx_q]) << (OFS + IB)) | (32'(req_idx_q) << OFS);
  assign req.WR_REQ_LEN   = req_len(LINE_WORDS);
  assign req.RD_REQ_START = (state_q == ST_RF_REQ);
  assign req.RD_REQ_ADDR  = rf_addr_q;
  assign req.RD_REQ_LEN   = req_len(LINE_WORDS);
  assign req.WR_REQ_MEM_WDATA = ram_b_rdata;

  // Port B is shared: refill writes in RF_WAIT, write-back reads otherwise.
  assign ram_b_we   = (state_q == ST_RF_WAIT) && req.RD_REQ_MEM_WE;
  assign b_off      = (state_q == ST_RF_WAIT) ? req.RD_REQ_MEM_ADDR : req.WR_REQ_MEM_ADDR;
  assign ram_a_addr = AW'((32'(a_idx) << WA) | 32'(a_off));
  assign ram_b_addr = AW'((32'(req_idx_q) << WA) | 32'(b_off));

  fmrv32im_cache_dpram #(.DEPTH(LINES * LINE_WORDS), .AW(AW)) u_ram (
    .CLK     (CLK),
    .RST     (RST),
    .a_en    (hit),
    .a_we    (D_MEM_WSTB),
    .a_addr  (ram_a_addr),
    .a_wdata (D_MEM_WDATA),
    .a_rdata (D_MEM_RDATA),
    .b_we    (ram_b_we),
    .b_addr  (ram_b_addr),
    .b_wdata (req.RD_REQ_MEM_RDATA),
    .b_rdata (ram_b_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
      req_idx_q    <= '0;
      rf_addr_q    <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      if (FLUSH_REQ) flush_pend_q <= 1'b1;
      if (hit && (D_MEM_WSTB != 4'b0000)) dirty_q[a_idx] <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (flush_pend_q || FLUSH_REQ) begin
            flush_pend_q <= 1'b0;
            req_idx_q    <= '0;
            state_q      <= ST_FL_SCAN;
          end else if (D_MEM_ENA && in_window && !hit) begin
            req_idx_q <= a_idx;
            rf_addr_q <= {D_MEM_ADDR[31:OFS], {OFS{1'b0}}};
            // A dirty victim must be written back first, never overwritten.
            if (valid_q[a_idx] && dirty_q[a_idx]) begin
              if (req.WR_REQ_READY) state_q <= ST_WB_REQ;
            end else if (req.RD_REQ_READY) begin
              state_q <= ST_RF_REQ;
            end
          end
        end
        ST_WB_REQ:  state_q <= ST_WB_WAIT;
        ST_WB_WAIT: if (req.WR_REQ_READY) state_q <= ST_RF_REQ;
        ST_RF_REQ:  state_q <= ST_RF_WAIT;
        ST_RF_WAIT: begin
          if (req.RD_REQ_READY) begin
            valid_q[req_idx_q] <= 1'b1;
            dirty_q[req_idx_q] <= 1'b0;
            tag_q[req_idx_q]   <= rf_tag;
            state_q            <= ST_IDLE;
          end
        end
        ST_FL_SCAN: begin
          if (line_dirty) begin
            if (req.WR_REQ_READY) state_q <= ST_FL_REQ;
          end else if (last_idx) begin
            flush_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            req_idx_q <= req_idx_q + 1'b1;
          end
        end
        ST_FL_REQ: state_q <= ST_FL_WAIT;
        ST_FL_WAIT: begin
          if (req.WR_REQ_READY) begin
            dirty_q[req_idx_q] <= 1'b0;
            if (last_idx) begin
              flush_done_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              req_idx_q <= req_idx_q + 1'b1;
              state_q   <= ST_FL_SCAN;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmrv32im_dcache_wb.sv
// Directed bench for fmrv32im_dcache_wb (LINES=4, LINE_WORDS=16) with
// behavioural write/read burst masters backed by a sparse memory model.
module tb_fmrv32im_dcache_wb;
  import fmrv32im_cache_pkg::*;

  localparam int LINES = 4;
  localparam int LW    = 16;
  localparam int WA    = 4;
  localparam int TMO   = 400;

  logic        CLK = 1'b0;
  logic        RST;
  logic        D_MEM_ENA;
  logic [3:0]  D_MEM_WSTB;
  logic [31:0] D_MEM_ADDR;
  logic [31:0] D_MEM_WDATA;
  logic        D_MEM_WAIT;
  logic [31:0] D_MEM_RDATA;
  logic        D_MEM_BADMEM_EXCPT;
  logic        FLUSH_REQ;
  logic        FLUSH_DONE;
  logic [2:0]  DBG_STATE;

  fmrv32im_dcache_wb_if #(.WA(WA)) bus ();

  fmrv32im_dcache_wb #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .D_MEM_ENA          (D_MEM_ENA),
    .D_MEM_WSTB         (D_MEM_WSTB),
    .D_MEM_ADDR         (D_MEM_ADDR),
    .D_MEM_WDATA        (D_MEM_WDATA),
    .D_MEM_WAIT         (D_MEM_WAIT),
    .D_MEM_RDATA        (D_MEM_RDATA),
    .D_MEM_BADMEM_EXCPT (D_MEM_BADMEM_EXCPT),
    .FLUSH_REQ          (FLUSH_REQ),
    .FLUSH_DONE         (FLUSH_DONE),
    .DBG_STATE          (DBG_STATE),
    .req                (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int wb_count = 0;
  int rd_count = 0;
  int done_count = 0;
  int rd_seen_wb = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wb_exp_q[$];
  logic [31:0] rd_exp_q[$];
  logic [31:0] bk [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Backing memory: untouched word at byte address a reads as
  // 0x100 + word-in-line + ((line number - 1) << 16), so line 0x40 holds 0x100+k.
  function automatic logic [31:0] model_word(input logic [31:0] a);
    if (bk.exists(a)) return bk[a];
    return 32'h100 + 32'(a[5:2]) + ((32'(a[15:6]) - 32'd1) << 16);
  endfunction

  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (FLUSH_DONE) done_count++;
    end
  end

  // ---------------- write-back burst master ----------------
  initial begin
    logic [31:0] base;
    bus.WR_REQ_READY    = 1'b1;
    bus.WR_REQ_MEM_ADDR = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.WR_REQ_START && !RST) begin
        base = bus.WR_REQ_ADDR;
        wb_count++;
        if (wb_exp_q.size() == 0) check("wb_unexpected", base, 32'hFFFF_FFFF);
        else check("wb_addr", base, wb_exp_q.pop_front());
        check("wb_len", 32'(bus.WR_REQ_LEN), 32'(LW * 4));
        bus.WR_REQ_READY    = 1'b0;
        bus.WR_REQ_MEM_ADDR = '0;
        for (int k = 0; k < LW; k++) begin
          @(posedge CLK);
          #1;
          bk[base + 32'(4 * k)] = bus.WR_REQ_MEM_WDATA;
          if (k + 1 < LW) bus.WR_REQ_MEM_ADDR = WA'(k + 1);
        end
        bus.WR_REQ_READY = 1'b1;
      end
    end
  end

  // ---------------- refill burst master ----------------
  initial begin
    logic [31:0] base;
    bus.RD_REQ_READY     = 1'b1;
    bus.RD_REQ_MEM_WE    = 1'b0;
    bus.RD_REQ_MEM_ADDR  = '0;
    bus.RD_REQ_MEM_RDATA = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.RD_REQ_START && !RST) begin
        base = bus.RD_REQ_ADDR;
        rd_count++;
        rd_seen_wb = wb_count;
        if (rd_exp_q.size() == 0) check("rd_unexpected", base, 32'hFFFF_FFFF);
        else check("rd_addr", base, rd_exp_q.pop_front());
        check("rd_len", 32'(bus.RD_REQ_LEN), 32'(LW * 4));
        bus.RD_REQ_READY = 1'b0;
        for (int k = 0; k < LW; k++) begin
          @(posedge CLK);
          #1;
          if (RST) break;
          bus.RD_REQ_MEM_WE    = 1'b1;
          bus.RD_REQ_MEM_ADDR  = WA'(k);
          bus.RD_REQ_MEM_RDATA = model_word(base + 32'(4 * k));
          // Last word and READY share a cycle.
          if (k == LW - 1) bus.RD_REQ_READY = 1'b1;
        end
        @(posedge CLK);
        #1;
        bus.RD_REQ_MEM_WE = 1'b0;
        bus.RD_REQ_READY  = 1'b1;
      end
    end
  end

  // ---------------- core driver ----------------
  task automatic access(input logic [31:0] addr, input logic [3:0] wstb,
                        input logic [31:0] wdata, output int waited);
    waited      = 0;
    D_MEM_ENA   = 1'b1;
    D_MEM_ADDR  = addr;
    D_MEM_WSTB  = wstb;
    D_MEM_WDATA = wdata;
    #1;
    while (D_MEM_WAIT && waited < TMO) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    check("wait_bound", 32'(D_MEM_WAIT), 32'd0);
    @(negedge CLK);
    D_MEM_ENA  = 1'b0;
    D_MEM_WSTB = 4'b0000;
    if (wstb == 4'b0000) check("rdata", D_MEM_RDATA, exp_q.pop_front());
  endtask

  task automatic do_flush(output int cyc);
    FLUSH_REQ = 1'b1;
    @(negedge CLK);
    FLUSH_REQ = 1'b0;
    cyc = 0;
    while (done_count == 0 && cyc < TMO) begin
      @(negedge CLK);
      cyc++;
    end
    repeat (3) @(negedge CLK);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w, cyc, wb0, rd0;
    RST         = 1'b1;
    D_MEM_ENA   = 1'b0;
    D_MEM_WSTB  = 4'b0000;
    D_MEM_ADDR  = '0;
    D_MEM_WDATA = '0;
    FLUSH_REQ   = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    check("rst_state", 32'(DBG_STATE), 32'(ST_IDLE));
    check("rst_wait", 32'(D_MEM_WAIT), 32'd0);
    check("rst_rdata", D_MEM_RDATA, 32'd0);
    check("rst_flush_done", 32'(FLUSH_DONE), 32'd0);
    check("rst_wr_start", 32'(bus.WR_REQ_START), 32'd0);
    check("rst_rd_start", 32'(bus.RD_REQ_START), 32'd0);

    // Cold read miss, refill, then hit
    rd_exp_q.push_back(32'h40);
    exp_q.push_back(32'h100);
    access(32'h40, 4'b0000, '0, w);
    check("cold_waited", 32'(w > 0), 32'd1);
    check("cold_no_wb", 32'(wb_count), 32'd0);
    check("cold_rd_count", 32'(rd_count), 32'd1);

    exp_q.push_back(32'h103);
    access(32'h4C, 4'b0000, '0, w);
    check("hit_no_wait", 32'(w), 32'd0);

    // Partial write hit then read back
    access(32'h44, 4'b0011, 32'hAAAA_BBBB, w);
    check("wr_hit_no_wait", 32'(w), 32'd0);
    exp_q.push_back(32'h0000_BBBB);
    access(32'h44, 4'b0000, '0, w);

    // Conflict miss on dirty line: write-back of 0x40 before refill of 0x140
    wb_exp_q.push_back(32'h40);
    rd_exp_q.push_back(32'h140);
    exp_q.push_back(32'h0004_0101);
    access(32'h144, 4'b0000, '0, w);
    check("evict_wb_count", 32'(wb_count), 32'd1);
    check("evict_wb_first", 32'(rd_seen_wb), 32'd1);
    check("evict_wdata1", bk[32'h44], 32'h0000_BBBB);
    check("evict_wdata0", bk[32'h40], 32'h100);

    // Two dirty lines (idx 0 and idx 1), then flush
    rd_exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF_0100);
    access(32'h0, 4'b0000, '0, w);
    access(32'h8, 4'b1111, 32'h1234_5678, w);
    access(32'h148, 4'b1100, 32'hCAFE_0000, w);
    wb_exp_q.push_back(32'h0);
    wb_exp_q.push_back(32'h140);
    wb0 = wb_count;
    done_count = 0;
    do_flush(cyc);
    check("flush_bursts", 32'(wb_count - wb0), 32'd2);
    check("flush_done_pulses", 32'(done_count), 32'd1);
    check("flush_data0", bk[32'h8], 32'h1234_5678);
    check("flush_data1", bk[32'h148], 32'hCAFE_0102);
    check("flush_idle", 32'(DBG_STATE), 32'(ST_IDLE));

    // Re-flush: nothing dirty, no bursts, prompt single DONE
    wb0 = wb_count;
    done_count = 0;
    do_flush(cyc);
    check("reflush_bursts", 32'(wb_count - wb0), 32'd0);
    check("reflush_pulses", 32'(done_count), 32'd1);
    check("reflush_fast", 32'(cyc <= LINES + 2), 32'd1);

    // Valid kept after flush
    exp_q.push_back(32'hCAFE_0102);
    access(32'h148, 4'b0000, '0, w);
    check("post_flush_hit", 32'(w), 32'd0);

    // Out-of-window access: exception, no wait, no request, write dropped
    rd0 = rd_count;
    wb0 = wb_count;
    D_MEM_ENA   = 1'b1;
    D_MEM_ADDR  = 32'h8000_0148;
    D_MEM_WSTB  = 4'b1111;
    D_MEM_WDATA = 32'hDEAD_BEEF;
    #1;
    check("badmem_excpt", 32'(D_MEM_BADMEM_EXCPT), 32'd1);
    check("badmem_no_wait", 32'(D_MEM_WAIT), 32'd0);
    repeat (3) @(negedge CLK);
    D_MEM_ENA  = 1'b0;
    D_MEM_WSTB = 4'b0000;
    repeat (2) @(negedge CLK);
    check("badmem_no_rd", 32'(rd_count - rd0), 32'd0);
    check("badmem_no_wb", 32'(wb_count - wb0), 32'd0);
    exp_q.push_back(32'hCAFE_0102);
    access(32'h148, 4'b0000, '0, w);
    check("badmem_wr_dropped_hit", 32'(w), 32'd0);

    // Reset in the middle of a refill
    rd_exp_q.push_back(32'h2C0);
    D_MEM_ENA  = 1'b1;
    D_MEM_ADDR = 32'h2C0;
    D_MEM_WSTB = 4'b0000;
    cyc = 0;
    while (DBG_STATE != ST_RF_WAIT && cyc < TMO) begin
      @(negedge CLK);
      cyc++;
    end
    check("reach_rf_wait", 32'(DBG_STATE), 32'(ST_RF_WAIT));
    repeat (4) @(negedge CLK);
    RST       = 1'b1;
    D_MEM_ENA = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("rst_mid_state", 32'(DBG_STATE), 32'(ST_IDLE));
    check("rst_mid_rdata", D_MEM_RDATA, 32'd0);
    repeat (2) @(negedge CLK);

    rd0 = rd_count;
    rd_exp_q.push_back(32'h2C0);
    exp_q.push_back(32'h000A_0100);
    access(32'h2C0, 4'b0000, '0, w);
    check("rst_remiss_waited", 32'(w > 0), 32'd1);
    check("rst_remiss_burst", 32'(rd_count - rd0), 32'd1);

    // Lines valid before the reset are gone too
    rd_exp_q.push_back(32'h140);
    exp_q.push_back(32'hCAFE_0102);
    access(32'h148, 4'b0000, '0, w);
    check("rst_invalidated", 32'(w > 0), 32'd1);
    check("queues_drained", 32'(exp_q.size() + wb_exp_q.size() + rd_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
